vga_text_addr_gen: RTL and testbench

//  Registered text-mode address generator for the VGA device controller. Tracks h/v counts

---
 rtl/vga_text_pkg.sv | 27 ++
 rtl/vga_text_scroll_mul.sv | 48 ++++
 rtl/vga_text_addr_gen.sv | 163 ++++++++++++++++
 tb/tb_vga_text_addr_gen.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_text_pkg.sv
// Shared definitions for the VGA text address generator: FSM encoding, 640x480 text-mode
// defaults and a width helper for the row/glyph counters.
package vga_text_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_READY,
        ST_ACTIVE
    } text_state_t;

    localparam int H_START_DEF = 144;
    localparam int V_START_DEF = 35;
    localparam int COLS_DEF    = 80;
    localparam int ROWS_DEF    = 60;
    localparam int GLYPH_W_DEF = 8;
    localparam int GLYPH_H_DEF = 8;

    // Bits needed to index 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) width++;
        return width;
    endfunction

endpackage

// File: rtl/vga_text_scroll_mul.sv
// Sequential shift-add multiplier producing scroll_row * COLS, one multiplier bit per
// enabled cycle; done is high during the cycle that retires the last bit.
module vga_text_scroll_mul #(
    parameter int COLS   = 80,
    parameter int ROW_W  = 6,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              start,
    input  logic [ROW_W-1:0]  multiplier,
    output logic [ADDR_W-1:0] product,
    output logic              done
);

    logic [ADDR_W-1:0] mcand;
    logic [ROW_W-1:0]  mplier;
    logic [ROW_W-1:0]  steps_left;
    logic              running;

    assign done = running && (steps_left == ROW_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product    <= '0;
            mcand      <= '0;
            mplier     <= '0;
            steps_left <= '0;
            running    <= 1'b0;
        end else if (en) begin
            if (start) begin
                product    <= '0;
                mcand      <= ADDR_W'(COLS);
                mplier     <= multiplier;
                steps_left <= ROW_W'(ROW_W);
                running    <= 1'b1;
            end else if (running) begin
                if (mplier[0]) product <= product + mcand;
                mcand      <= mcand << 1;
                mplier     <= mplier >> 1;
                steps_left <= steps_left - ROW_W'(1);
                if (steps_left == ROW_W'(1)) running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/vga_text_addr_gen.sv
// Registered text-mode address generator with hardware vertical scroll.
// Optional blinking cursor output is enabled by defining VGA_TEXT_CURSOR_EN.
module vga_text_addr_gen import vga_text_pkg::*; #(
    parameter int H_START = H_START_DEF,
    parameter int V_START = V_START_DEF,
    parameter int COLS    = COLS_DEF,
    parameter int ROWS    = ROWS_DEF,
    parameter int GLYPH_W = GLYPH_W_DEF,
    parameter int GLYPH_H = GLYPH_H_DEF,
    parameter int ADDR_W  = 13,
    parameter int CNT_W   = 10,
`ifdef VGA_TEXT_CURSOR_EN
    parameter int BLINK_LOG = 5,
`endif
    localparam int ROW_W  = clog2(ROWS),
    localparam int GCOL_W = clog2(GLYPH_W),
    localparam int GROW_W = clog2(GLYPH_H)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_en_i,
    input  logic [CNT_W-1:0]  h_count_i,
    input  logic [CNT_W-1:0]  v_count_i,
    input  logic [ROW_W-1:0]  scroll_row_i,
`ifdef VGA_TEXT_CURSOR_EN
    input  logic [ADDR_W-1:0] cursor_addr_i,
    output logic              cursor_o,
`endif
    output logic [ADDR_W-1:0] char_addr_o,
    output logic [GROW_W-1:0] glyph_row_o,
    output logic [GCOL_W-1:0] glyph_col_o,
    output logic              active_o,
    output logic              busy_o
);

    localparam logic [CNT_W-1:0]  H_LINE_START = CNT_W'(H_START - 1);
    localparam logic [CNT_W-1:0]  H_FIRST      = CNT_W'(H_START);
    localparam logic [CNT_W-1:0]  H_VIS_END    = CNT_W'(H_START + COLS * GLYPH_W);
    localparam logic [CNT_W-1:0]  V_LATCH      = CNT_W'(V_START - 2);
    localparam logic [CNT_W-1:0]  V_FIRST      = CNT_W'(V_START);
    localparam logic [CNT_W-1:0]  V_DONE       = CNT_W'(V_START + ROWS * GLYPH_H);
    localparam logic [ROW_W-1:0]  ROW_LAST     = ROW_W'(ROWS - 1);
    localparam logic [GCOL_W-1:0] GCOL_LAST    = GCOL_W'(GLYPH_W - 1);
    localparam logic [GROW_W-1:0] GROW_LAST    = GROW_W'(GLYPH_H - 1);
    localparam logic [ADDR_W-1:0] COLS_A       = ADDR_W'(COLS);

    text_state_t       state;
    logic [ROW_W-1:0]  scroll_q;
    logic [ROW_W-1:0]  phys_row;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] addr_cnt;
    logic [GCOL_W-1:0] col_cnt;
    logic [GROW_W-1:0] line_in_glyph;
    logic [ADDR_W-1:0] mul_product;
    logic              mul_done;

    wire h_zero      = (h_count_i == '0);
    wire frame_latch = (state == ST_IDLE) && h_zero && (v_count_i == V_LATCH);
    wire frame_end   = (state == ST_ACTIVE) && h_zero && (v_count_i == V_DONE);
    wire visible_pix = (state == ST_ACTIVE) && (h_count_i >= H_FIRST) && (h_count_i < H_VIS_END);
    wire [ROW_W-1:0] scroll_sel =
        ({1'b0, scroll_row_i} >= (ROW_W + 1)'(ROWS)) ? '0 : scroll_row_i;

    vga_text_scroll_mul #(
        .COLS   (COLS),
        .ROW_W  (ROW_W),
        .ADDR_W (ADDR_W)
    ) u_scroll_mul (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (pix_en_i),
        .start      (frame_latch),
        .multiplier (scroll_sel),
        .product    (mul_product),
        .done       (mul_done)
    );

    // Frame sequencing plus per-pixel address walk; the scroll base is only ever multiplied
    // once per frame, after which text rows advance by adding COLS with explicit wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            scroll_q      <= '0;
            phys_row      <= '0;
            row_base      <= '0;
            addr_cnt      <= '0;
            col_cnt       <= '0;
            line_in_glyph <= '0;
            char_addr_o   <= '0;
            glyph_row_o   <= '0;
            glyph_col_o   <= '0;
            active_o      <= 1'b0;
            busy_o        <= 1'b0;
        end else if (pix_en_i) begin
            case (state)
                ST_IDLE: if (frame_latch) begin
                    state    <= ST_MUL;
                    busy_o   <= 1'b1;
                    scroll_q <= scroll_sel;
                end
                ST_MUL: if (mul_done) begin
                    state  <= ST_READY;
                    busy_o <= 1'b0;
                end
                ST_READY: if (h_zero && v_count_i == V_FIRST) begin
                    state         <= ST_ACTIVE;
                    row_base      <= mul_product;
                    line_in_glyph <= '0;
                    phys_row      <= scroll_q;
                end
                ST_ACTIVE: if (frame_end) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            active_o <= visible_pix;

            if (state == ST_ACTIVE && h_count_i == H_LINE_START) begin
                addr_cnt <= row_base;
                col_cnt  <= '0;
            end

            if (visible_pix) begin
                char_addr_o <= addr_cnt;
                glyph_col_o <= col_cnt;
                glyph_row_o <= line_in_glyph;
                col_cnt     <= (col_cnt == GCOL_LAST) ? '0 : col_cnt + GCOL_W'(1);
                if (col_cnt == GCOL_LAST) addr_cnt <= addr_cnt + ADDR_W'(1);
            end

            if (state == ST_ACTIVE && h_count_i == H_VIS_END) begin
                if (line_in_glyph == GROW_LAST) begin
                    line_in_glyph <= '0;
                    if (phys_row == ROW_LAST) begin
                        phys_row <= '0;
                        row_base <= '0;
                    end else begin
                        phys_row <= phys_row + ROW_W'(1);
                        row_base <= row_base + COLS_A;
                    end
                end else begin
                    line_in_glyph <= line_in_glyph + GROW_W'(1);
                end
            end
        end
    end

`ifdef VGA_TEXT_CURSOR_EN
    logic [BLINK_LOG-1:0] blink_cnt;

    // Cursor lights the bottom glyph line of its cell during the "on" half of the blink period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            cursor_o  <= 1'b0;
        end else if (pix_en_i) begin
            if (frame_end) blink_cnt <= blink_cnt + BLINK_LOG'(1);
            cursor_o <= visible_pix && (addr_cnt == cursor_addr_i)
                        && (line_in_glyph == GROW_LAST) && blink_cnt[BLINK_LOG-1];
        end
    end
`endif

endmodule

// File: tb/tb_vga_text_addr_gen.sv
// Directed bench for vga_text_addr_gen: default 80x60 instance plus a 40x30 / 16x16-glyph
// instance driven from the same compressed h/v count sequence.
module tb_vga_text_addr_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_en;
    logic [9:0]  h_count;
    logic [9:0]  v_count;
    logic [5:0]  scroll;
    logic [4:0]  scroll2;
    logic [12:0] char_addr;
    logic [2:0]  glyph_row;
    logic [2:0]  glyph_col;
    logic        active;
    logic        busy;
    logic [12:0] char_addr2;
    logic [3:0]  glyph_row2;
    logic [3:0]  glyph_col2;
    logic        active2;
    logic        busy2;
`ifdef VGA_TEXT_CURSOR_EN
    logic [12:0] cursor_addr = 13'd81;
    logic        cursor;
    logic        cursor2;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    vga_text_addr_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pix_en_i     (pix_en),
        .h_count_i    (h_count),
        .v_count_i    (v_count),
        .scroll_row_i (scroll),
`ifdef VGA_TEXT_CURSOR_EN
        .cursor_addr_i(cursor_addr),
        .cursor_o     (cursor),
`endif
        .char_addr_o  (char_addr),
        .glyph_row_o  (glyph_row),
        .glyph_col_o  (glyph_col),
        .active_o     (active),
        .busy_o       (busy)
    );

    vga_text_addr_gen #(
        .COLS    (40),
        .ROWS    (30),
        .GLYPH_W (16),
        .GLYPH_H (16)
    ) dut_wide (
        .clk          (clk),
        .rst_n        (rst_n),
        .pix_en_i     (pix_en),
        .h_count_i    (h_count),
        .v_count_i    (v_count),
        .scroll_row_i (scroll2),
`ifdef VGA_TEXT_CURSOR_EN
        .cursor_addr_i(cursor_addr),
        .cursor_o     (cursor2),
`endif
        .char_addr_o  (char_addr2),
        .glyph_row_o  (glyph_row2),
        .glyph_col_o  (glyph_col2),
        .active_o     (active2),
        .busy_o       (busy2)
    );

    task automatic applyStimulus(input int h, input int v, input logic en);
        h_count = 10'(h);
        v_count = 10'(v);
        pix_en  = en;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic runLines(input int v_from, input int v_to);
        for (int v = v_from; v <= v_to; v++) begin
            applyStimulus(143, v, 1'b1);
            applyStimulus(784, v, 1'b1);
        end
    endtask

    task automatic runToActive(input int s);
        scroll = 6'(s);
        applyStimulus(0, 33, 1'b1);
        checkOutput("busy_start", 32'(busy), 1);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(i, 33, 1'b1);
            checkOutput("busy_mul", 32'(busy), 1);
        end
        applyStimulus(6, 33, 1'b1);
        checkOutput("busy_done", 32'(busy), 0);
        applyStimulus(0, 35, 1'b1);
        checkOutput("blank_at_entry", 32'(active), 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        pix_en  = 1'b0;
        h_count = '0;
        v_count = '0;
        scroll  = '0;
        scroll2 = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_addr", 32'(char_addr), 0);
        checkOutput("reset_active", 32'(active), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        rst_n = 1'b1;
        applyStimulus(0, 0, 1'b1);

        // Frame A: scroll 0, full frame walked to reach the last cells of both grids.
        runToActive(0);
        applyStimulus(143, 35, 1'b1);
        checkOutput("pre_visible_blank", 32'(active), 0);
        applyStimulus(144, 35, 1'b1);
        checkOutput("first_active", 32'(active), 1);
        checkOutput("first_addr", 32'(char_addr), 0);
        checkOutput("first_col", 32'(glyph_col), 0);
        applyStimulus(145, 35, 1'b0);
        checkOutput("pix_en_hold_col", 32'(glyph_col), 0);
        for (int i = 1; i < 8; i++) begin
            applyStimulus(144 + i, 35, 1'b1);
            checkOutput("row0_addr", 32'(char_addr), 0);
            checkOutput("row0_col", 32'(glyph_col), i);
            checkOutput("wide_row0_col", 32'(glyph_col2), i);
        end
        applyStimulus(152, 35, 1'b1);
        checkOutput("second_char_addr", 32'(char_addr), 1);
        checkOutput("second_char_col", 32'(glyph_col), 0);
        checkOutput("wide_same_char", 32'(char_addr2), 0);
        checkOutput("wide_col8", 32'(glyph_col2), 8);
        for (int h = 153; h < 160; h++) applyStimulus(h, 35, 1'b1);
        applyStimulus(160, 35, 1'b1);
        checkOutput("wide_second_char", 32'(char_addr2), 1);
        checkOutput("wide_second_col", 32'(glyph_col2), 0);
        applyStimulus(784, 35, 1'b1);
        checkOutput("end_line_blank", 32'(active), 0);
        checkOutput("end_line_hold", 32'(char_addr), 2);
        runLines(36, 41);
        applyStimulus(143, 42, 1'b1);
        applyStimulus(144, 42, 1'b1);
        checkOutput("glyph_row7", 32'(glyph_row), 7);
        checkOutput("glyph_row7_addr", 32'(char_addr), 0);
        applyStimulus(784, 42, 1'b1);
        applyStimulus(143, 43, 1'b1);
        applyStimulus(144, 43, 1'b1);
        checkOutput("row1_addr", 32'(char_addr), 80);
        checkOutput("row1_glyph_row", 32'(glyph_row), 0);
        checkOutput("wide_row8", 32'(glyph_row2), 8);
        checkOutput("wide_row8_addr", 32'(char_addr2), 0);
        applyStimulus(784, 43, 1'b1);
        runLines(44, 50);
        applyStimulus(143, 51, 1'b1);
        applyStimulus(144, 51, 1'b1);
        checkOutput("wide_row1_addr", 32'(char_addr2), 40);
        checkOutput("wide_row1_glyph", 32'(glyph_row2), 0);
        applyStimulus(784, 51, 1'b1);
        runLines(52, 513);
        applyStimulus(143, 514, 1'b1);
        for (int h = 144; h <= 783; h++) applyStimulus(h, 514, 1'b1);
        checkOutput("last_addr", 32'(char_addr), 4799);
        checkOutput("last_col", 32'(glyph_col), 7);
        checkOutput("last_row", 32'(glyph_row), 7);
        checkOutput("wide_last_addr", 32'(char_addr2), 1199);
        checkOutput("wide_last_col", 32'(glyph_col2), 15);
        checkOutput("wide_last_row", 32'(glyph_row2), 15);
        applyStimulus(784, 514, 1'b1);
        applyStimulus(0, 515, 1'b1);
        applyStimulus(143, 516, 1'b1);
        applyStimulus(144, 516, 1'b1);
        checkOutput("after_frame_blank", 32'(active), 0);

        // Frame B: scroll 59 wraps to RAM row 0 on screen row 1; mid-frame change ignored.
        runToActive(59);
        applyStimulus(143, 35, 1'b1);
        applyStimulus(144, 35, 1'b1);
        checkOutput("scroll59_row0", 32'(char_addr), 4720);
        applyStimulus(784, 35, 1'b1);
        runLines(36, 42);
        applyStimulus(143, 43, 1'b1);
        applyStimulus(144, 43, 1'b1);
        checkOutput("scroll59_row1_wrap", 32'(char_addr), 0);
        applyStimulus(784, 43, 1'b1);
        runLines(44, 199);
        applyStimulus(143, 200, 1'b1);
        scroll = 6'd5;
        applyStimulus(144, 200, 1'b1);
        applyStimulus(784, 200, 1'b1);
        runLines(201, 202);
        applyStimulus(143, 203, 1'b1);
        applyStimulus(144, 203, 1'b1);
        checkOutput("midframe_scroll_ignored", 32'(char_addr), 1600);
        applyStimulus(0, 515, 1'b1);

        // Frame C: the scroll written mid-frame takes effect now.
        runToActive(5);
        applyStimulus(143, 35, 1'b1);
        applyStimulus(144, 35, 1'b1);
        checkOutput("scroll5_row0", 32'(char_addr), 400);
        applyStimulus(0, 515, 1'b1);

        // Frame D: out-of-range scroll behaves as 0, then reset mid-frame.
        runToActive(62);
        applyStimulus(143, 35, 1'b1);
        applyStimulus(144, 35, 1'b1);
        checkOutput("scroll_oor_row0", 32'(char_addr), 0);
        applyStimulus(784, 35, 1'b1);
        runLines(36, 42);
        applyStimulus(143, 43, 1'b1);
        applyStimulus(144, 43, 1'b1);
        checkOutput("scroll_oor_row1", 32'(char_addr), 80);
        applyStimulus(784, 43, 1'b1);
        runLines(44, 99);
        applyStimulus(143, 100, 1'b1);
        for (int h = 144; h <= 300; h++) applyStimulus(h, 100, 1'b1);
        checkOutput("pre_reset_active", 32'(active), 1);
        checkOutput("pre_reset_col", 32'(glyph_col), 4);
        rst_n = 1'b0;
        applyStimulus(301, 100, 1'b1);
        checkOutput("midreset_addr", 32'(char_addr), 0);
        checkOutput("midreset_row", 32'(glyph_row), 0);
        checkOutput("midreset_col", 32'(glyph_col), 0);
        checkOutput("midreset_active", 32'(active), 0);
        checkOutput("midreset_busy", 32'(busy), 0);
        rst_n = 1'b1;
        applyStimulus(143, 101, 1'b1);
        applyStimulus(144, 101, 1'b1);
        checkOutput("post_reset_blank", 32'(active), 0);
        applyStimulus(0, 515, 1'b1);

        // Frame E: normal operation resumes after reset.
        runToActive(3);
        applyStimulus(143, 35, 1'b1);
        applyStimulus(144, 35, 1'b1);
        checkOutput("resume_row0", 32'(char_addr), 240);
        applyStimulus(784, 35, 1'b1);
        runLines(36, 42);
        applyStimulus(143, 43, 1'b1);
        applyStimulus(144, 43, 1'b1);
        checkOutput("resume_row1", 32'(char_addr), 320);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
